// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    typedef logic [3:0] bcd_nibble_t;

    localparam bcd_nibble_t ADD3_THRESHOLD = 4'd5;

    // Upper bound on DIGITS supported by the leading-zero helper.
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Digit idx is a leading zero when it and every digit above it are zero; digit 0 never is.
    function automatic logic is_lead_zero(input logic [4*MAX_DIGITS-1:0] bcd,
                                          input int idx,
                                          input int digits);
        logic all_zero;
        all_zero = (idx != 0);
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i >= idx) && (i < digits)) begin
                all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
            end else begin
                all_zero = all_zero;
            end
        end
        return all_zero;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Per-digit shift-add-3 corrector: adds 3 to a BCD digit of 5 or more.
module bin2bcd_seq_bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  bcd_nibble_t digit_i,
    output bcd_nibble_t digit_o
);

    // Pre-shift correction so the digit stays valid BCD after doubling.
    always_comb begin
        if (digit_i >= ADD3_THRESHOLD) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// registered digits, leading-zero blank flags and overflow flag.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o,
    output logic                  ovf_o
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1'b1));

    state_t                  state_q;
    logic [WIDTH-1:0]        bin_q;
    logic [4*DIGITS-1:0]     digits_q;
    logic [4*DIGITS-1:0]     digits_adj_s;
    logic [4*DIGITS-1:0]     digits_d;
    logic                    ovf_acc_q;
    logic                    ovf_acc_d;
    logic [CNT_W-1:0]        count_q;
    logic [4*MAX_DIGITS-1:0] digits_ext_s;
    logic [DIGITS-1:0]       blank_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bin2bcd_seq_bcd_add3 u_add3 (
            .digit_i (digits_q[4*g +: 4]),
            .digit_o (digits_adj_s[4*g +: 4])
        );
    end

    // Shift step of {overflow, digits, binary}; the bit leaving the top digit sticks in overflow.
    always_comb begin
        digits_d  = {digits_adj_s[4*DIGITS-2:0], bin_q[WIDTH-1]};
        ovf_acc_d = ovf_acc_q | digits_adj_s[4*DIGITS-1];
        digits_ext_s = '0;
        digits_ext_s[4*DIGITS-1:0] = digits_q;
        blank_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blank_d[i] = is_lead_zero(digits_ext_s, i, DIGITS);
        end
    end

    // Conversion FSM; display outputs only move on the done cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            digits_q  <= '0;
            ovf_acc_q <= 1'b0;
            count_q   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            bcd_o     <= '0;
            blank_o   <= BLANK_RST;
            ovf_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bin_q     <= bin_i;
                        digits_q  <= '0;
                        ovf_acc_q <= 1'b0;
                        count_q   <= '0;
                        busy_o    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    digits_q  <= digits_d;
                    bin_q     <= bin_q << 1;
                    ovf_acc_q <= ovf_acc_d;
                    count_q   <= count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    bcd_o   <= digits_q;
                    ovf_o   <= ovf_acc_q;
                    blank_o <= blank_d;
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: an 8-bit/3-digit instance and a 5-bit/1-digit instance.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [7:0]  bin_a;
    logic [4:0]  bin_b;
    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [2:0]  blank_a;
    logic        busy_b, done_b, ovf_b;
    logic [3:0]  bcd_b;
    logic [0:0]  blank_b;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .bin_i(bin_a),
        .busy_o(busy_a), .done_o(done_a), .bcd_o(bcd_a), .blank_o(blank_a), .ovf_o(ovf_a)
    );

    bin2bcd_seq #(.WIDTH(5), .DIGITS(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .bin_i(bin_b),
        .busy_o(busy_b), .done_o(done_b), .bcd_o(bcd_b), .blank_o(blank_b), .ovf_o(ovf_b)
    );

    typedef struct packed {
        logic [11:0] bcd;
        logic [2:0]  blank;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic exp_t model(input int v, input int digits);
        exp_t e;
        int   r;
        int   low;
        e = '0;
        r = v;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.ovf = (r != 0);
        low = v % pow10(digits);
        for (int i = 1; i < digits; i++) e.blank[i] = (low < pow10(i));
        return e;
    endfunction

    // Drive one conversion, optionally pulsing start on edge k+j for each set bit j of pulses.
    task automatic run_conv(input bit sel, input int v, input logic [31:0] pulses, input string tag);
        int   lat;
        int   busy_low;
        int   want_lat;
        exp_t e;
        want_lat = sel ? 6 : 9;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; bin_b = 5'(v); end
        else     begin start_a = 1'b1; bin_a = 8'(v); end
        sb_q.push_back(model(v, sel ? 1 : 3));
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        bin_a = 8'hA5;  bin_b = 5'h0A;
        check({tag, " busy_at_k"}, 32'(sel ? busy_b : busy_a), 32'd1);
        lat = 0;
        busy_low = 0;
        while (!(sel ? done_b : done_a) && lat < 20) begin
            if (sel) start_b = pulses[lat+1];
            else     start_a = pulses[lat+1];
            @(negedge clk);
            lat++;
            if (!(sel ? done_b : done_a) && !(sel ? busy_b : busy_a)) busy_low++;
        end
        start_a = 1'b0; start_b = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(want_lat));
        check({tag, " busy_gap"}, 32'(busy_low), 32'd0);
        check({tag, " busy_at_done"}, 32'(sel ? busy_b : busy_a), 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " bcd"},   sel ? 32'(bcd_b) : 32'(bcd_a), 32'(e.bcd));
            check({tag, " blank"}, sel ? 32'(blank_b) : 32'(blank_a), 32'(e.blank));
            check({tag, " ovf"},   32'(sel ? ovf_b : ovf_a), 32'(e.ovf));
        end
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(sel ? done_b : done_a), 32'd0);
    endtask

    initial begin
        int extra;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = 8'd0; bin_b = 5'd0;
        repeat (2) @(negedge clk);
        check("rst busy",  32'(busy_a), 32'd0);
        check("rst done",  32'(done_a), 32'd0);
        check("rst bcd",   32'(bcd_a), 32'd0);
        check("rst blank", 32'(blank_a), 32'h6);
        check("rst ovf",   32'(ovf_a), 32'd0);
        check("rst blank_b", 32'(blank_b), 32'd0);
        rst = 1'b0;

        run_conv(1'b0, 0,   32'd0, "c0");
        run_conv(1'b0, 21,  32'd0, "c21");
        run_conv(1'b0, 255, 32'd0, "c255");
        run_conv(1'b0, 100, 32'd0, "c100");
        run_conv(1'b0, 17,  (32'd1 << 3) | (32'd1 << 9), "c17");

        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a || busy_a) extra++;
        end
        check("c17 no_second_conv", 32'(extra), 32'd0);
        check("c17 hold_bcd", 32'(bcd_a), 32'h017);

        @(negedge clk);
        start_a = 1'b1; bin_a = 8'd99;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid busy",  32'(busy_a), 32'd0);
        check("rst_mid bcd",   32'(bcd_a), 32'd0);
        check("rst_mid blank", 32'(blank_a), 32'h6);
        check("rst_mid ovf",   32'(ovf_a), 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_a || busy_a) extra++;
        end
        check("rst_mid no_done", 32'(extra), 32'd0);
        run_conv(1'b0, 42, 32'd0, "c42");

        run_conv(1'b1, 31, 32'd0, "w5_31");
        run_conv(1'b1, 9,  32'd0, "w5_9");
        run_conv(1'b1, 10, 32'd0, "w5_10");

        check("sb drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter for the score and bet displays. It takes a binary value from game control and converts it with the shift-add-3 method, one bit per clock. It presents the result as packed BCD nibbles, one nibble per 7-segment decoder input, plus leading-zero blank flags for the top-level display mux. Output digits stay stable between conversions, so the decoders never see intermediate values.

## Interface
- WIDTH, 8, bit width of the binary input; must be ≥ 1
- DIGITS, 3, number of BCD digits produced; must be ≥ 1
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  request a conversion of bin_in; sampled only in IDLE
- bin_in  input  WIDTH  unsigned value to convert; captured on the accepted start edge
- busy  output  1  high while a conversion is in progress (SHIFT and DONE states)
- done  output  1  single-cycle pulse; bcd_out, blank and ovf are updated in the same cycle
- bcd_out  output  4*DIGITS  packed BCD; nibble 0 (bits 3:0) is the units digit
- blank  output  DIGITS  bit i set means digit i is a leading zero; bit 0 is always 0
- ovf  output  1  set when bin_in > 10^DIGITS − 1; bcd_out then holds the low DIGITS digits

## Operation
- State machine: IDLE → SHIFT → DONE → IDLE.
- IDLE, start=1: capture bin_in into the shift register, clear the BCD scratch digits and the overflow accumulator, set count=0, go to SHIFT. When start=0, stay in IDLE.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3.
  - Shift {overflow accumulator, scratch digits, binary register} left by 1.
  - The bit leaving the top digit ORs into the overflow accumulator.
  - count+1. After the WIDTH-th shift, go to DONE.
- DONE: load bcd_out from the scratch digits and ovf from the accumulator, compute blank, pulse done, go to IDLE.
- blank[i], for i ≥ 1: set iff digits i..DIGITS−1 are all zero. blank[0] is hard 0.
- start is ignored while busy=1, including in DONE. No queuing.
- bin_in is only sampled on the accepting edge and may change afterwards.
- count width is clog2(WIDTH+1). Scratch digits never exceed 9 after an add-3/shift step.

## Timing
- Reset values: busy=0, done=0, ovf=0, bcd_out=0, blank={DIGITS-1{1'b1}},1'b0 (matches the value 0). State is IDLE.
- start sampled high at edge k: busy=1 from edge k.
- SHIFT runs edges k+1..k+WIDTH. At edge k+WIDTH+1 (DONE exit): done=1 for one cycle, outputs updated, busy=0.
- Latency is WIDTH+1 cycles from accepting edge to done. Throughput is one conversion per WIDTH+2 cycles; start held high re-arms on the first IDLE cycle.
- bcd_out, blank and ovf change only on the done cycle and hold otherwise.
- rst asserted mid-conversion: immediate return to IDLE with the reset output values. The partial result is discarded and no done pulse is issued.

## Structure
- Shared package holds the BCD nibble type, the add-3 threshold constant (5), the FSM state enum, and a function for the leading-zero mask.
- One natural sub-module: bcd_add3, a combinational per-digit corrector (4-bit in, 4-bit out, +3 when ≥ 5), instantiated DIGITS times via generate.
- All outputs are registered; no combinational path from start/bin_in to any output.

## Test plan
- Reset, then bin_in=0, start pulse → done 9 cycles later; bcd_out=12'h000, blank=3'b110, ovf=0.
- bin_in=21 → bcd_out=12'h021, blank=3'b100; done asserted exactly at edge k+9, busy high for edges k..k+8.
- bin_in=255 → bcd_out=12'h255, blank=3'b000, ovf=0. Then bin_in=100 → 12'h100, blank=3'b000.
- start pulsed at edges k+3 and k+9 during a conversion of 17 → ignored; a single done with 12'h017, no second conversion.
- rst asserted at edge k+4 of a conversion of 99 → outputs return to reset values immediately, no done pulse. A new start after release converts 42 → 12'h042.
- WIDTH=5, DIGITS=1, bin_in=31 → done after 6 cycles, bcd_out=4'h1, ovf=1; bin_in=9 → 4'h9, ovf=0.
